// File: rtl/mem_access_ctrl.sv
// Memory access sequencer: drives MAR, RAM strobes and MDR control for LDR/STR.
// Every output is a register loaded from the next-state decode.
module mem_access_ctrl #(
    parameter int AW          = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic [1:0]    op,
    input  logic [AW-1:0] addr_in,
    output logic [AW-1:0] mar_addr,
    output logic          ram_ce,
    output logic          ram_we,
    output logic [1:0]    en_mdr,
    output logic          busy,
    output logic          done,
    output logic          err
);

    // state   | meaning
    // IDLE    | waiting for req; illegal op pulses err
    // RD_WAIT | RAM read wait states (ce=1, we=0)
    // LATCH   | MDR latches RAM data (en_mdr=01)
    // STAGE   | MDR latches register data (en_mdr=10)
    // WR_WAIT | RAM write wait states (ce=1, we=1)
    // DONE    | one-cycle completion pulse
    typedef enum logic [2:0] {
        IDLE, RD_WAIT, LATCH, STAGE, WR_WAIT, DONE
    } state_t;

    localparam int WAIT_EFF = (WAIT_CYCLES < 1) ? 1 : ((WAIT_CYCLES > 15) ? 15 : WAIT_CYCLES);
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_EFF - 1);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       load_mar;
    logic       ce_nxt, we_nxt, busy_nxt, done_nxt, err_nxt;
    logic [1:0] mdr_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            mar_addr <= '0;
            ram_ce   <= 1'b0;
            ram_we   <= 1'b0;
            en_mdr   <= 2'b00;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            if (load_mar) mar_addr <= addr_in;
            ram_ce <= ce_nxt;
            ram_we <= we_nxt;
            en_mdr <= mdr_nxt;
            busy   <= busy_nxt;
            done   <= done_nxt;
            err    <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load_mar  = 1'b0;
        err_nxt   = 1'b0;
        ce_nxt    = 1'b0;
        we_nxt    = 1'b0;
        mdr_nxt   = 2'b00;
        done_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (req) begin
                    if (op == 2'b01) begin
                        state_nxt = RD_WAIT;
                        cnt_nxt   = CNT_LOAD;
                        load_mar  = 1'b1;
                    end else if (op == 2'b10) begin
                        state_nxt = STAGE;
                        load_mar  = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            RD_WAIT: begin
                if (cnt == 4'd0) state_nxt = LATCH;
                else             cnt_nxt   = cnt - 4'd1;
            end
            LATCH: state_nxt = DONE;
            STAGE: begin
                state_nxt = WR_WAIT;
                cnt_nxt   = CNT_LOAD;
            end
            WR_WAIT: begin
                if (cnt == 4'd0) state_nxt = DONE;
                else             cnt_nxt   = cnt - 4'd1;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // Outputs follow the state being entered so they are valid right after the edge.
        case (state_nxt)
            RD_WAIT: ce_nxt = 1'b1;
            LATCH: begin
                ce_nxt  = 1'b1;
                mdr_nxt = 2'b01;
            end
            STAGE:   mdr_nxt = 2'b10;
            WR_WAIT: begin
                ce_nxt  = 1'b1;
                we_nxt  = 1'b1;
                mdr_nxt = 2'b10;
            end
            DONE:    done_nxt = 1'b1;
            default: ;
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl at WAIT_CYCLES = 2, 1 and 15 sharing one stimulus.
module tb_mem_access_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req = 1'b0;
    logic [1:0] op  = 2'b00;
    logic [7:0] addr_in = 8'h00;

    logic [7:0] mar2, mar1, mar15;
    logic       ce2, we2, busy2, done2, err2;
    logic       ce1, we1, busy1, done1, err1;
    logic       ce15, we15, busy15, done15, err15;
    logic [1:0] mdr2, mdr1, mdr15;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.AW(8), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .req(req), .op(op), .addr_in(addr_in),
        .mar_addr(mar2), .ram_ce(ce2), .ram_we(we2), .en_mdr(mdr2),
        .busy(busy2), .done(done2), .err(err2));

    mem_access_ctrl #(.AW(8), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .req(req), .op(op), .addr_in(addr_in),
        .mar_addr(mar1), .ram_ce(ce1), .ram_we(we1), .en_mdr(mdr1),
        .busy(busy1), .done(done1), .err(err1));

    mem_access_ctrl #(.AW(8), .WAIT_CYCLES(15)) dut15 (
        .clk(clk), .rst(rst), .req(req), .op(op), .addr_in(addr_in),
        .mar_addr(mar15), .ram_ce(ce15), .ram_we(we15), .en_mdr(mdr15),
        .busy(busy15), .done(done15), .err(err15));

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Packed {busy, done, err, ce, we, en_mdr[1:0]} expected c cycles after the accepting edge.
    function automatic int exp_vec(input bit is_ldr, input int w, input int c);
        bit b, d, ce, we;
        logic [1:0] m;
        b = (c >= 1) && (c <= w + 2);
        d = (c == w + 2);
        if (is_ldr) begin
            ce = (c >= 1) && (c <= w + 1);
            we = 1'b0;
            m  = (c == w + 1) ? 2'b01 : 2'b00;
        end else begin
            ce = (c >= 2) && (c <= w + 1);
            we = ce;
            m  = ((c >= 1) && (c <= w + 1)) ? 2'b10 : 2'b00;
        end
        return int'({b, d, 1'b0, ce, we, m});
    endfunction

    function automatic int vec(input logic b, input logic d, input logic e,
                               input logic ce, input logic we, input logic [1:0] m);
        return int'({b, d, e, ce, we, m});
    endfunction

    // One request, then walk 18 cycles checking all three instances against the timing model.
    task automatic run_txn(input bit is_ldr, input logic [7:0] a, input string tag);
        req = 1'b1;
        op = is_ldr ? 2'b01 : 2'b10;
        addr_in = a;
        tick();
        req = 1'b0;
        addr_in = ~a;
        for (int c = 1; c <= 18; c++) begin
            chk({tag, "_w2"},  vec(busy2, done2, err2, ce2, we2, mdr2),       exp_vec(is_ldr, 2, c));
            chk({tag, "_w1"},  vec(busy1, done1, err1, ce1, we1, mdr1),       exp_vec(is_ldr, 1, c));
            chk({tag, "_w15"}, vec(busy15, done15, err15, ce15, we15, mdr15), exp_vec(is_ldr, 15, c));
            if (c == 1 || c == 18) begin
                chk({tag, "_mar2"},  int'(mar2),  int'(a));
                chk({tag, "_mar15"}, int'(mar15), int'(a));
            end
            tick();
        end
    endtask

    initial begin
        #2;
        chk("rst_w2",   vec(busy2, done2, err2, ce2, we2, mdr2), 0);
        chk("rst_mar2", int'(mar2), 0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        run_txn(1'b1, 8'h3C, "ldr");
        run_txn(1'b0, 8'hA5, "str");

        // Illegal ops: err pulse only, MAR keeps the last accepted address.
        req = 1'b1; op = 2'b11; addr_in = 8'h55;
        tick();
        req = 1'b0;
        chk("ill11_w2", vec(busy2, done2, err2, ce2, we2, mdr2), 7'b0010000);
        chk("ill11_w15", vec(busy15, done15, err15, ce15, we15, mdr15), 7'b0010000);
        chk("ill11_mar", int'(mar2), 8'hA5);
        tick();
        chk("ill11_clr", int'(err2), 0);
        req = 1'b1; op = 2'b00; addr_in = 8'h66;
        tick();
        req = 1'b0;
        chk("ill00_err", int'(err1), 1);
        chk("ill00_mar", int'(mar1), 8'hA5);
        tick();
        chk("ill00_clr", vec(busy1, done1, err1, ce1, we1, mdr1), 0);

        // req held for 10 edges: W=2 accepts at edges 0 and 5 only.
        req = 1'b1; op = 2'b01; addr_in = 8'h10;
        for (int c = 1; c <= 10; c++) begin
            tick();
            addr_in = 8'h10 + 8'(c);
            chk("b2b_done", int'(done2), (c % 5 == 4) ? 1 : 0);
            chk("b2b_busy", int'(busy2), (c % 5 != 0) ? 1 : 0);
            chk("b2b_mar", int'(mar2), (c <= 5) ? 8'h10 : 8'h15);
        end
        req = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("b2b_idle", int'(busy15) | int'(busy2) | int'(busy1), 0);

        // Reset during the second WR_WAIT cycle.
        req = 1'b1; op = 2'b10; addr_in = 8'hC3;
        tick();
        req = 1'b0;
        tick();
        tick();
        chk("pre_rst_we", int'(we2), 1);
        rst = 1'b0;
        #1;
        chk("rst_mid_w2", vec(busy2, done2, err2, ce2, we2, mdr2), 0);
        chk("rst_mid_mar", int'(mar2), 0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_nodone", int'(done2), 0);
        end
        run_txn(1'b0, 8'h5A, "str_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter AW, default 8, address width of the MAR and RAM address bus.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, RAM access wait states, legal range 1..15; value 0 behaves as 1.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  1  access request, sampled only in IDLE.
REQ-006 SHALL have port op  input  2  2'b01 = LDR (RAM->MDR), 2'b10 = STR (MDR->RAM); 2'b00 and 2'b11 are illegal.
REQ-007 SHALL have port addr_in  input  AW  effective address from the datapath.
REQ-008 SHALL have port mar_addr  output  AW  registered RAM address (MAR).
REQ-009 SHALL have port ram_ce  output  1  RAM chip enable.
REQ-010 SHALL have port ram_we  output  1  RAM write enable, valid only while ram_ce=1.
REQ-011 SHALL have port en_mdr  output  2  MDR control: 01 = latch RAM data, 10 = latch register data, 00 = idle.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse.
REQ-014 SHALL have port err  output  1  one-cycle pulse on a request with an illegal op.

Function
REQ-015 SHALL register all outputs; no output depends combinationally on any input.
REQ-016 SHALL implement FSM states IDLE, RD_WAIT, LATCH, STAGE, WR_WAIT and DONE, plus a 4-bit wait counter.
REQ-017 IDLE, on req=1 with op=01: SHALL load mar_addr<=addr_in and go to RD_WAIT.
REQ-018 IDLE, on req=1 with op=10: SHALL load mar_addr<=addr_in and go to STAGE.
REQ-019 IDLE, on req=1 with an illegal op: SHALL stay in IDLE, pulse err for exactly 1 cycle, leave mar_addr unchanged and make no RAM access.
REQ-020 RD_WAIT: SHALL drive ram_ce=1, ram_we=0, en_mdr=00 for WAIT_CYCLES cycles, then go to LATCH.
REQ-021 LATCH: SHALL drive ram_ce=1, ram_we=0, en_mdr=01 for 1 cycle, then go to DONE.
REQ-022 STAGE: SHALL drive en_mdr=10, ram_ce=0 for 1 cycle so the MDR captures register data, then go to WR_WAIT.
REQ-023 WR_WAIT: SHALL drive ram_ce=1, ram_we=1, en_mdr=10 (MDR holds write data) for WAIT_CYCLES cycles, then go to DONE.
REQ-024 DONE: SHALL drive done=1, ram_ce=0, ram_we=0, en_mdr=00 for 1 cycle, then go to IDLE.
REQ-025 For LDR, the register file captures data_mdr2reg on the clock edge that ends the DONE cycle.
REQ-026 done SHALL be high in exactly the (WAIT_CYCLES+2)th cycle after the accepting edge, for both LDR and STR.
REQ-027 req, op and addr_in SHALL be ignored outside IDLE; minimum issue interval is WAIT_CYCLES+3 cycles.
REQ-028 mar_addr SHALL stay constant from the accepting edge until the next accepted request.
REQ-029 ram_we=1 SHALL never coincide with ram_ce=0 or with en_mdr=01.
REQ-030 done and err SHALL never be high in the same cycle.

Reset
REQ-031 On rst=0, SHALL immediately force: state IDLE, counter 0, mar_addr=0, ram_ce=0, ram_we=0, en_mdr=00, busy=0, done=0, err=0.
REQ-032 Reset asserted mid-transaction SHALL abort it, deassert ram_we asynchronously, and produce no done pulse.
REQ-033 After rst deasserts, the first rising edge with req=1 in IDLE SHALL be accepted normally.

Verification
REQ-034 LDR, WAIT_CYCLES=2, addr_in=8'h3C, req pulse -> mar_addr=3C; ram_ce=1 for 3 cycles; en_mdr=01 in cycle 3; done in cycle 4; busy cycles 1-4.
REQ-035 STR, WAIT_CYCLES=2, addr_in=8'hA5 -> en_mdr=10 cycles 1-3; ram_we=1 cycles 2-3 only; done in cycle 4.
REQ-036 req with op=11 in IDLE -> err=1 for 1 cycle, busy=0, ram_ce=0, mar_addr unchanged.
REQ-037 req held high for 10 cycles with op=01 -> back-to-back transactions; each done exactly WAIT_CYCLES+2 cycles after acceptance; no request accepted while busy.
REQ-038 rst=0 asserted in the second WR_WAIT cycle -> ram_we=0 and mar_addr=0 immediately; no done; a new STR after reset completes normally.
REQ-039 WAIT_CYCLES=1 and WAIT_CYCLES=15 runs of LDR and STR -> done in cycle 3 and cycle 17 respectively.
